// File: rtl/mpx_muldiv.sv
// rtl/mpx_muldiv.sv - MULT/MULTU/DIV/DIVU unit feeding the HI/LO register file.
// Fixed-latency multiply, 32-cycle restoring divide, busy/strobe decoded from state.
module mpx_muldiv #(
  parameter int MUL_LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        opcode_valid_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] operand_ra_i,
  input  logic [31:0] operand_rb_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        muldiv_o,
  output logic [31:0] muldiv_hi_o,
  output logic [31:0] muldiv_lo_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_t;

  state_t      state;
  logic [4:0]  count;
  logic [32:0] mul_a;
  logic [32:0] mul_b;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] rem;
  logic [31:0] quot;
  logic        sign_q;
  logic        sign_r;

  logic        accept;
  logic        is_signed;
  logic [31:0] ra_abs;
  logic [31:0] rb_abs;
  logic [63:0] product;
  logic [32:0] rem_shift;
  logic        rem_ge;
  logic [31:0] rem_next;
  logic [31:0] quot_next;

  assign busy_o   = (state == ST_MUL) || (state == ST_DIV);
  assign muldiv_o = (state == ST_DONE);
  assign accept   = opcode_valid_i && !busy_o && !flush_i;

  assign is_signed = !op_i[0];
  assign ra_abs    = (is_signed && operand_ra_i[31]) ? -operand_ra_i : operand_ra_i;
  assign rb_abs    = (is_signed && operand_rb_i[31]) ? -operand_rb_i : operand_rb_i;

  // Sign-extending the 33-bit operands to 64 bits keeps the truncated product exact.
  assign product = {{31{mul_a[32]}}, mul_a} * {{31{mul_b[32]}}, mul_b};

  // 33-bit compare so a 0x80000000 divisor cannot overflow; the difference fits 32 bits.
  assign rem_shift = {rem, dividend[31]};
  assign rem_ge    = rem_shift >= {1'b0, divisor};
  assign rem_next  = rem_ge ? (rem_shift[31:0] - divisor) : rem_shift[31:0];
  assign quot_next = {quot[30:0], rem_ge};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= ST_IDLE;
      count       <= '0;
      mul_a       <= '0;
      mul_b       <= '0;
      dividend    <= '0;
      divisor     <= '0;
      rem         <= '0;
      quot        <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      muldiv_hi_o <= '0;
      muldiv_lo_o <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept && op_i[1]) begin
            sign_q   <= is_signed && (operand_ra_i[31] ^ operand_rb_i[31]);
            sign_r   <= is_signed && operand_ra_i[31];
            dividend <= ra_abs;
            divisor  <= rb_abs;
            rem      <= '0;
            quot     <= '0;
            count    <= 5'd31;
            state    <= ST_DIV;
          end else if (accept) begin
            mul_a <= {is_signed && operand_ra_i[31], operand_ra_i};
            mul_b <= {is_signed && operand_rb_i[31], operand_rb_i};
            count <= 5'(MUL_LATENCY - 1);
            state <= ST_MUL;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_MUL: begin
          if (flush_i) begin
            state <= ST_IDLE;
          end else if (count == 5'd0) begin
            muldiv_hi_o <= product[63:32];
            muldiv_lo_o <= product[31:0];
            state       <= ST_DONE;
          end else begin
            count <= count - 5'd1;
          end
        end
        ST_DIV: begin
          if (flush_i) begin
            state <= ST_IDLE;
          end else begin
            rem      <= rem_next;
            quot     <= quot_next;
            dividend <= {dividend[30:0], 1'b0};
            if (count == 5'd0) begin
              muldiv_lo_o <= sign_q ? -quot_next : quot_next;
              muldiv_hi_o <= sign_r ? -rem_next : rem_next;
              state       <= ST_DONE;
            end else begin
              count <= count - 5'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mpx_muldiv.sv
// tb/tb_mpx_muldiv.sv - self-checking bench for mpx_muldiv.
// Table vectors, hand-written flush/reset/back-to-back sequences, random ops vs arithmetic model.
module tb_mpx_muldiv;

  logic        clk_i;
  logic        rst_i;
  logic        opcode_valid_i;
  logic [1:0]  op_i;
  logic [31:0] operand_ra_i;
  logic [31:0] operand_rb_i;
  logic        flush_i;
  logic        busy_o;
  logic        muldiv_o;
  logic [31:0] muldiv_hi_o;
  logic [31:0] muldiv_lo_o;

  int n_checks = 0;
  int n_fail   = 0;

  mpx_muldiv #(.MUL_LATENCY(2)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .opcode_valid_i (opcode_valid_i),
    .op_i           (op_i),
    .operand_ra_i   (operand_ra_i),
    .operand_rb_i   (operand_rb_i),
    .flush_i        (flush_i),
    .busy_o         (busy_o),
    .muldiv_o       (muldiv_o),
    .muldiv_hi_o    (muldiv_hi_o),
    .muldiv_lo_o    (muldiv_lo_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic with truncating division, div-by-zero as documented.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sp;
    longint          sq;
    longint          sr;
    longint unsigned up;
    case (op)
      2'b00: begin
        sp = longint'(signed'(a)) * longint'(signed'(b));
        return sp;
      end
      2'b01: begin
        up = {32'b0, a} * {32'b0, b};
        return up;
      end
      2'b10: begin
        if (b == 32'd0) return {a, (a[31] ? 32'h1 : 32'hFFFFFFFF)};
        sq = longint'(signed'(a)) / longint'(signed'(b));
        sr = longint'(signed'(a)) % longint'(signed'(b));
        return {sr[31:0], sq[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    opcode_valid_i = 1'b1;
    op_i           = op;
    operand_ra_i   = a;
    operand_rb_i   = b;
    @(posedge clk_i);
    #1 opcode_valid_i = 1'b0;
  endtask

  task automatic wait_done(output int lat, output logic [31:0] hi, output logic [31:0] lo);
    lat = -1;
    hi  = '0;
    lo  = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk_i);
      if (muldiv_o) begin
        lat = c;
        hi  = muldiv_hi_o;
        lo  = muldiv_lo_o;
        break;
      end
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] hi, output logic [31:0] lo);
    @(negedge clk_i);
    start(op, a, b);
    wait_done(lat, hi, lo);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      3:       return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int          lat;
    int          pulses;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [63:0] exp;

    vecs[0] = '{"mult_neg_x2",    2'b00, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 3};
    vecs[1] = '{"multu_max",      2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 3};
    vecs[2] = '{"mult_min_sq",    2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 3};
    vecs[3] = '{"div_m7_2",       2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    vecs[4] = '{"divu_big",       2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 33};
    vecs[5] = '{"div_ovf",        2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
    vecs[6] = '{"div_neg_by0",    2'b10, 32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 32'h00000001, 33};
    vecs[7] = '{"divu_by0",       2'b11, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 33};
    vecs[8] = '{"divu_100_7",     2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       33};

    rst_i          = 1'b0;
    opcode_valid_i = 1'b0;
    op_i           = 2'b00;
    operand_ra_i   = '0;
    operand_rb_i   = '0;
    flush_i        = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_pulse", 32'(muldiv_o), 32'd0);
    chk("rst_hi", muldiv_hi_o, 32'd0);
    chk("rst_lo", muldiv_lo_o, 32'd0);
    rst_i = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, hi, lo);
      chk({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].lat));
      chk({vecs[i].name, "_hi"}, hi, vecs[i].hi);
      chk({vecs[i].name, "_lo"}, lo, vecs[i].lo);
    end

    // Cycle-by-cycle view of one multiply.
    @(negedge clk_i);
    start(2'b00, 32'hFFFFFFFF, 32'h2);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk_i);
      chk($sformatf("mul_busy_c%0d", c), 32'(busy_o), 32'((c == 1) || (c == 2)));
      chk($sformatf("mul_pulse_c%0d", c), 32'(muldiv_o), 32'(c == 3));
    end

    // Second multiply issued in the DONE cycle of the first.
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, hi, lo);
    chk("b2b_first_lat", 32'(lat), 32'd3);
    start(2'b01, 32'd3, 32'd5);
    wait_done(lat, hi, lo);
    chk("b2b_second_lat", 32'(lat), 32'd3);
    chk("b2b_second_hi", hi, 32'd0);
    chk("b2b_second_lo", lo, 32'hF);

    // Flush mid-divide: results from the previous op must survive.
    run_op(2'b11, 32'd100, 32'd7, lat, hi, lo);
    @(negedge clk_i);
    start(2'b10, 32'hFFFFFFF9, 32'h2);
    repeat (9) @(negedge clk_i);
    @(negedge clk_i);
    chk("flush_busy_c10", 32'(busy_o), 32'd1);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    chk("flush_busy_c11", 32'(busy_o), 32'd0);
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_i);
      if (muldiv_o) pulses++;
    end
    chk("flush_no_pulse", 32'(pulses), 32'd0);
    chk("flush_hi_kept", muldiv_hi_o, 32'd2);
    chk("flush_lo_kept", muldiv_lo_o, 32'd14);

    // Issue and flush together: the issue is dropped.
    flush_i = 1'b1;
    start(2'b11, 32'd9, 32'd3);
    flush_i = 1'b0;
    @(negedge clk_i);
    chk("vf_busy", 32'(busy_o), 32'd0);
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_i);
      if (muldiv_o || busy_o) pulses++;
    end
    chk("vf_no_activity", 32'(pulses), 32'd0);

    for (int i = 0; i < 30; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = pick();
      rb  = pick();
      exp = model(rop, ra, rb);
      run_op(rop, ra, rb, lat, hi, lo);
      chk($sformatf("rnd%0d_lat op%0d %h %h", i, rop, ra, rb), 32'(lat), rop[1] ? 32'd33 : 32'd3);
      chk($sformatf("rnd%0d_hi op%0d %h %h", i, rop, ra, rb), hi, exp[63:32]);
      chk($sformatf("rnd%0d_lo op%0d %h %h", i, rop, ra, rb), lo, exp[31:0]);
    end

    // Asynchronous reset in the middle of a divide.
    run_op(2'b01, 32'd7, 32'd9, lat, hi, lo);
    @(negedge clk_i);
    start(2'b10, 32'hFFFFFFF9, 32'h2);
    repeat (14) @(negedge clk_i);
    chk("ar_busy_before", 32'(busy_o), 32'd1);
    #2 rst_i = 1'b0;
    #1;
    chk("ar_busy", 32'(busy_o), 32'd0);
    chk("ar_pulse", 32'(muldiv_o), 32'd0);
    chk("ar_hi", muldiv_hi_o, 32'd0);
    chk("ar_lo", muldiv_lo_o, 32'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    run_op(2'b01, 32'd2, 32'd2, lat, hi, lo);
    chk("ar_mul_lat", 32'(lat), 32'd3);
    chk("ar_mul_hi", hi, 32'd0);
    chk("ar_mul_lo", lo, 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
